dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder: the target end of the CPU MEM-stage load/store port.
//  - Accepts one load or store per valid/ready handshake.
//  - Inserts a programmable wait latency.
//  - Returns read data or a write acknowledge on a response handshake.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 84 ++++++++
 tb/tb_dmem_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU MEM-stage load/store request and response channel
interface dmem_responder_if #(parameter int ADDR_W = 5);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory answering one load/store at a time
module dmem_responder #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   s,
  output logic              busy
);
  localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYC);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       mem [DEPTH];
  logic              c_write, commit, in_range;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic [MW-1:0]     idx;
  // with no wait cycles the accepting edge is also the commit edge, so use the live request
  always_comb begin
    c_write  = state == IDLE ? s.req_write : wr_q;
    c_addr   = state == IDLE ? s.req_addr  : addr_q;
    c_wdata  = state == IDLE ? s.req_wdata : wdata_q;
    c_be     = state == IDLE ? s.req_be    : be_q;
    commit   = (state == IDLE && s.req_valid && WAIT_CYC == 0) || (state == WAIT && cnt == 4'd1);
    in_range = {1'b0, c_addr} < DEPTH_W;
    idx      = c_addr[MW-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      s.req_ready  <= 1'b1;
      s.resp_valid <= 1'b0;
      s.resp_rdata <= '0;
      s.resp_err   <= 1'b0;
      busy         <= 1'b0;
      cnt          <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (s.req_valid) begin
          state       <= WAIT;
          wr_q        <= s.req_write;
          addr_q      <= s.req_addr;
          wdata_q     <= s.req_wdata;
          be_q        <= s.req_be;
          cnt         <= WC;
          s.req_ready <= 1'b0;
          busy        <= 1'b1;
        end
        WAIT: cnt <= cnt - 4'd1;
        RESP: if (s.resp_ready) begin
          state        <= IDLE;
          s.resp_valid <= 1'b0;
          s.req_ready  <= 1'b1;
          busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        state        <= RESP;
        s.resp_valid <= 1'b1;
        s.resp_err   <= !in_range;
        s.resp_rdata <= (!c_write && in_range) ? mem[idx] : '0;
        if (c_write && in_range)
          for (int b = 0; b < 4; b++)
            if (c_be[b]) mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random load/store traffic against a word-array model
module tb_dmem_responder;
  localparam int AW = 5, DEPTH = 16, WAIT_CYC = 2;
  logic clk = 1'b0, rst_n = 1'b0, busy;
  int n_checks = 0, n_errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] rd;
  dmem_responder_if #(.ADDR_W(AW)) bus ();
  dmem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask
  task automatic xact(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int bp, output logic [31:0] got);
    logic [31:0] exp_d, held;
    logic exp_e;
    int n;
    exp_e = int'(a) >= DEPTH;
    exp_d = '0;
    if (!exp_e && !w) exp_d = model[a[3:0]];
    if (!exp_e && w)
      for (int b = 0; b < 4; b++) if (be[b]) model[a[3:0]][8*b +: 8] = d[8*b +: 8];
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_be = be;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(bus.req_ready), 32'd0);
    n = 1;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(WAIT_CYC + 1));
    chk("rdata", bus.resp_rdata, exp_d);
    chk("err", 32'(bus.resp_err), 32'(exp_e));
    got = bus.resp_rdata;
    held = bus.resp_rdata;
    for (int i = 0; i < bp; i++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.req_wdata = $urandom; bus.req_be = 4'hF;
      @(posedge clk); @(negedge clk);
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_rdata", bus.resp_rdata, held);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("retire_valid", 32'(bus.resp_valid), 32'd0);
    chk("retire_busy", 32'(busy), 32'd0);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0; bus.resp_ready = 1'b0;
    clear_model();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    xact(1'b0, 5'd7, '0, '0, 0, rd);
    chk("rst_load7", rd, 32'h0);
    xact(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 0, rd);
    chk("store_rdata", rd, 32'h0);
    xact(1'b0, 5'd3, '0, '0, 0, rd);
    chk("load3", rd, 32'hDEADBEEF);
    xact(1'b1, 5'd3, 32'h11223344, 4'b0101, 0, rd);
    xact(1'b0, 5'd3, '0, '0, 5, rd);
    chk("byte_en", rd, 32'hDE22BE44);
    xact(1'b1, 5'd4, 32'h0BADF00D, 4'hF, 0, rd);
    xact(1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 0, rd);
    chk("err_rdata", rd, 32'h0);
    xact(1'b0, 5'd4, '0, '0, 0, rd);
    chk("err_nowrite", rd, 32'h0BADF00D);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 5'd1;
    bus.req_wdata = 32'hCAFEF00D; bus.req_be = 4'hF;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    chk("midrst_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    xact(1'b0, 5'd1, '0, '0, 0, rd);
    chk("midrst_load1", rd, 32'h0);
    xact(1'b0, 5'd3, '0, '0, 0, rd);
    chk("midrst_load3", rd, 32'h0);
    for (int t = 0; t < 60; t++)
      xact(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 3), rd);
    for (int i = 0; i < DEPTH; i++) xact(1'b0, AW'(i), '0, '0, 0, rd);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
